// File: rtl/dpy_point_queue.sv
// Type 30 display point queue: accepts CPU point commands, converts ones'-complement
// AC/IO coordinates to screen space, and replays them as paced strobes.
module dpy_point_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP        = 4,
  parameter int X_WIDTH    = 10,
  parameter int Y_WIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [17:0]           ac,
  input  logic [17:0]           io,
  output logic                  ack,
  input  logic                  hold,
  output logic                  strobe,
  output logic [X_WIDTH-1:0]    x,
  output logic [Y_WIDTH-1:0]    y,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (GAP > 1) ? $clog2(GAP) : 1;

  typedef struct packed {
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
  } point_t;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

  point_t                mem [DEPTH];
  point_t                wr_pt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic [PW-1:0]         pace;
  logic                  push, pop, pace_ld;
  state_t                state, state_nxt;
  logic                  unused_lsbs;

  // Sign bit flipped turns ones' complement into offset binary; y is then
  // inverted so positive y lands at the top of the screen.
  assign wr_pt.x = {~ac[17], ac[16:18-X_WIDTH]};
  assign wr_pt.y = ~{~io[17], io[16:18-Y_WIDTH]};
  assign unused_lsbs = ^{ac[17-X_WIDTH:0], io[17-Y_WIDTH:0]};

  assign full  = (cnt == (DEPTH_LOG2+1)'(DEPTH));
  assign level = cnt;
  // A pending ack masks acceptance so a held req is queued only once.
  assign push  = !reset && req && !full && !ack;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_pt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ack    <= 1'b0;
    end else begin
      ack <= push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The pop itself costs one cycle in IDLE, so WAIT ends one count early to
  // keep strobe edges exactly GAP cycles apart under backlog.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    pace_ld   = 1'b0;
    case (state)
      IDLE: begin
        if (cnt != '0 && !hold) begin
          pop       = 1'b1;
          state_nxt = STROBE;
        end
      end
      STROBE: begin
        if (GAP == 1) begin
          if (cnt != '0 && !hold) pop = 1'b1;
          else                    state_nxt = IDLE;
        end else begin
          pace_ld   = 1'b1;
          state_nxt = (GAP == 2) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (pace == PW'(2)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)                pace <= '0;
    else if (pace_ld)         pace <= PW'(GAP - 1);
    else if (state == WAIT)   pace <= pace - 1'b1;
  end

  // x/y keep the last strobed point between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe <= 1'b0;
      x      <= '0;
      y      <= '0;
    end else begin
      strobe <= pop;
      if (pop) begin
        x <= mem[rd_ptr].x;
        y <= mem[rd_ptr].y;
      end
    end
  end

endmodule
